// File: rtl/hz_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : hz_pkg                                                        |
// | Purpose    : Shared types and constants for the hazard scoreboard:         |
// |              default Tuse/Tnew width, standard Tuse/Tnew encodings,        |
// |              scoreboard slot record and a small elaboration helper.        |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package hz_pkg;

   localparam int TNEW_W_DEF = 3;

   // Cycles until the D-stage instruction needs an operand.
   localparam logic [TNEW_W_DEF-1:0] TUSE_BR   = 3'd0;
   localparam logic [TNEW_W_DEF-1:0] TUSE_ALU  = 3'd1;
   localparam logic [TNEW_W_DEF-1:0] TUSE_ST   = 3'd2;
   localparam logic [TNEW_W_DEF-1:0] TUSE_NONE = 3'd7;

   // Cycles after entering E until the result is forwardable.
   localparam logic [TNEW_W_DEF-1:0] TNEW_ALU  = 3'd1;
   localparam logic [TNEW_W_DEF-1:0] TNEW_LD   = 3'd2;

   typedef struct packed {
      logic                  valid;
      logic [4:0]            dst;
      logic [TNEW_W_DEF-1:0] tnew;
   } sb_slot_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hz_md_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : hz_md_counter                                                 |
// | Purpose    : Busy counter for the multi-cycle mult/div unit. Loaded when   |
// |              a mult/div leaves D, counts down to zero; HI/LO users in D    |
// |              are held while it is nonzero.                                 |
// | Ports      : clk, reset       clock / synchronous active-high reset        |
// |              md_start         D holds mult/multu/div/divu                  |
// |              md_div           with md_start: 1=div, 0=mult                 |
// |              md_use           D touches HI/LO or starts the unit           |
// |              hz_stall         register-hazard stall from the scoreboard    |
// |              md_busy          counter nonzero                              |
// |              md_stall         D must stall because of the md unit          |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module hz_md_counter
   import hz_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start,
   input  logic md_div,
   input  logic md_use,
   input  logic hz_stall,
   output logic md_busy,
   output logic md_stall
);

   localparam int CNT_MAX = max_int(MULT_CYC, DIV_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_load;

   assign md_busy  = (r_cnt != '0);
   assign md_stall = md_use & md_busy;
   // A start only loads when the instruction actually moves into E.
   assign w_load   = md_start & ~hz_stall & ~md_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_load) begin
         r_cnt <= md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : hazard_scoreboard                                             |
// | Purpose    : Stall / forward-select unit for the MIPS pipeline. A shift-   |
// |              register scoreboard records in-flight writes (dst, Tnew) for  |
// |              stages E..E+NSTAGE-1; D-stage operands are compared against   |
// |              it to produce a stall and a forwarding source per operand.    |
// | Config     : HZ_MD_TRACK_EN  enables mult/div busy tracking (md_busy and   |
// |              HI/LO stall). Undefined: md_busy=0 and d_md_* are ignored.    |
// | Ports      : clk, reset             clock / synchronous active-high reset  |
// |              d_rs, d_rt             D source registers                     |
// |              d_tuse_rs, d_tuse_rt   cycles until D needs each source       |
// |              d_wa, d_tnew           D destination and its Tnew             |
// |              d_md_start/div/use     mult/div information for D             |
// |              stall                  freeze F/D, bubble into E              |
// |              fwd_rs_sel, fwd_rt_sel youngest matching slot (0 = regfile)   |
// |              md_busy                mult/div unit counting                 |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module hazard_scoreboard
   import hz_pkg::*;
#(
   parameter  int NSTAGE   = 3,
   parameter  int TNEW_W   = TNEW_W_DEF,
   parameter  int MULT_CYC = 5,
   parameter  int DIV_CYC  = 10,
   localparam int SW       = $clog2(NSTAGE + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        d_rs,
   input  logic [4:0]        d_rt,
   input  logic [TNEW_W-1:0] d_tuse_rs,
   input  logic [TNEW_W-1:0] d_tuse_rt,
   input  logic [4:0]        d_wa,
   input  logic [TNEW_W-1:0] d_tnew,
   input  logic              d_md_start,
   input  logic              d_md_div,
   input  logic              d_md_use,
   output logic              stall,
   output logic [SW-1:0]     fwd_rs_sel,
   output logic [SW-1:0]     fwd_rt_sel,
   output logic              md_busy
);

   // Slot k corresponds to pipeline stage D+k (1=E, 2=M, 3=W).
   logic [NSTAGE:1]   r_valid;
   logic [4:0]        r_dst  [1:NSTAGE];
   logic [TNEW_W-1:0] r_tnew [1:NSTAGE];

   logic          w_haz_rs;
   logic          w_haz_rt;
   logic          w_md_stall;
   logic [SW-1:0] w_fwd_rs;
   logic [SW-1:0] w_fwd_rt;

   // Walk from the oldest slot to the youngest so the youngest match is the
   // one left in the select; hazards are flagged on any matching slot.
   always_comb begin
      w_haz_rs = 1'b0;
      w_haz_rt = 1'b0;
      w_fwd_rs = '0;
      w_fwd_rt = '0;
      for (int k = NSTAGE; k >= 1; k--) begin
         if (r_valid[k] && (r_dst[k] == d_rs) && (d_rs != 5'd0)) begin
            w_fwd_rs = SW'(k);
            if (d_tuse_rs < r_tnew[k]) w_haz_rs = 1'b1;
         end
         if (r_valid[k] && (r_dst[k] == d_rt) && (d_rt != 5'd0)) begin
            w_fwd_rt = SW'(k);
            if (d_tuse_rt < r_tnew[k]) w_haz_rt = 1'b1;
         end
      end
   end

`ifdef HZ_MD_TRACK_EN
   hz_md_counter #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_counter (
      .clk      (clk),
      .reset    (reset),
      .md_start (d_md_start),
      .md_div   (d_md_div),
      .md_use   (d_md_use),
      .hz_stall (w_haz_rs | w_haz_rt),
      .md_busy  (md_busy),
      .md_stall (w_md_stall)
   );
`else
   logic unused_md;
   assign unused_md  = ^{d_md_start, d_md_div, d_md_use};
   assign md_busy    = 1'b0;
   assign w_md_stall = 1'b0;
`endif

   assign stall      = w_haz_rs | w_haz_rt | w_md_stall;
   assign fwd_rs_sel = w_fwd_rs;
   assign fwd_rt_sel = w_fwd_rt;

   // The scoreboard shifts every cycle, stall or not: a stalled D inserts a
   // bubble into slot 1 while older entries keep draining.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
         for (int k = 1; k <= NSTAGE; k++) begin
            r_dst[k]  <= '0;
            r_tnew[k] <= '0;
         end
      end else begin
         r_valid[1] <= ~stall & (d_wa != 5'd0);
         r_dst[1]   <= d_wa;
         r_tnew[1]  <= d_tnew;
         for (int k = 2; k <= NSTAGE; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_dst[k]   <= r_dst[k-1];
            r_tnew[k]  <= (r_tnew[k-1] != '0) ? (r_tnew[k-1] - TNEW_W'(1)) : '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_hazard_scoreboard                                          |
// | Purpose    : Directed self-checking bench for hazard_scoreboard with       |
// |              default parameters (NSTAGE=3, TNEW_W=3, MULT 5, DIV 10).      |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] d_rs, d_rt, d_wa;
   logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic       d_md_start, d_md_div, d_md_use;
   logic       stall, md_busy;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk        (clk),
      .reset      (reset),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_wa       (d_wa),
      .d_tnew     (d_tnew),
      .d_md_start (d_md_start),
      .d_md_div   (d_md_div),
      .d_md_use   (d_md_use),
      .stall      (stall),
      .fwd_rs_sel (fwd_rs_sel),
      .fwd_rt_sel (fwd_rt_sel),
      .md_busy    (md_busy)
   );

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Present a D-stage instruction; outputs settle 1 time unit later.
   task automatic drive(input int rs, input int trs, input int rt, input int trt,
                        input int wa, input int tn, input int mds, input int mdd,
                        input int mdu);
      d_rs       = 5'(rs);
      d_tuse_rs  = 3'(trs);
      d_rt       = 5'(rt);
      d_tuse_rt  = 3'(trt);
      d_wa       = 5'(wa);
      d_tnew     = 3'(tn);
      d_md_start = 1'(mds);
      d_md_div   = 1'(mdd);
      d_md_use   = 1'(mdu);
      #1;
   endtask

   task automatic idle();
      drive(0, 7, 0, 7, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;

      // Reset state, with a D operand that would match if any slot were valid.
      drive(8, 1, 8, 1, 0, 0, 0, 0, 0);
      check("rst_stall", stall, 0);
      check("rst_fwd_rs", fwd_rs_sel, 0);
      check("rst_fwd_rt", fwd_rt_sel, 0);
      check("rst_md_busy", md_busy, 0);

      // Load-use: lw $8 (tnew 2) then add using $8 at Tuse 1.
      drive(0, 7, 0, 7, 8, 2, 0, 0, 0);
      check("lw_issue_stall", stall, 0);
      tick();
      drive(8, 1, 0, 7, 10, 1, 0, 0, 0);
      check("lu_stall1", stall, 1);
      check("lu_fwd1", fwd_rs_sel, 1);
      tick();
      check("lu_stall2", stall, 0);
      check("lu_fwd2", fwd_rs_sel, 2);
      tick();

      // Branch after ALU: addu $9 (tnew 1), beq on $9 at Tuse 0.
      drive(0, 7, 0, 7, 9, 1, 0, 0, 0);
      check("alu_issue_stall", stall, 0);
      tick();
      drive(9, 0, 0, 7, 0, 0, 0, 0, 0);
      check("br_stall1", stall, 1);
      check("br_fwd1", fwd_rs_sel, 1);
      tick();
      check("br_stall2", stall, 0);
      check("br_fwd2", fwd_rs_sel, 2);
      tick();

      // $0: a write to $0 must not enter the scoreboard; rt=3 matches nothing.
      drive(0, 7, 0, 7, 0, 2, 0, 0, 0);
      tick();
      drive(0, 0, 3, 0, 0, 0, 0, 0, 0);
      check("r0_stall", stall, 0);
      check("r0_fwd_rs", fwd_rs_sel, 0);
      check("nomatch_fwd_rt", fwd_rt_sel, 0);
      tick();

      // Store data after lw: Tuse 2 == Tnew 2, no stall but forward.
      drive(0, 7, 0, 7, 4, 2, 0, 0, 0);
      tick();
      drive(0, 7, 4, 2, 0, 0, 0, 0, 0);
      check("st_stall", stall, 0);
      check("st_fwd_rt", fwd_rt_sel, 1);
      tick();

      // Duplicate destination: youngest slot wins.
      drive(0, 7, 0, 7, 5, 1, 0, 0, 0);
      tick();
      drive(0, 7, 0, 7, 5, 1, 0, 0, 0);
      check("dup_issue_stall", stall, 0);
      tick();
      drive(5, 7, 5, 7, 0, 0, 0, 0, 0);
      check("dup_fwd_rt", fwd_rt_sel, 1);
      check("dup_fwd_rs", fwd_rs_sel, 1);
      check("dup_stall", stall, 0);
      // Slots 1 and 2 hold $5; three idle cycles drop both off the end.
      tick();
      check("dup_age_fwd", fwd_rt_sel, 2);
      tick();
      check("dup_age_fwd3", fwd_rt_sel, 3);
      tick();
      check("drop_fwd", fwd_rt_sel, 0);
      idle();
      tick();

      // Mult/div tracking.
      drive(0, 7, 0, 7, 0, 0, 1, 1, 1);
      check("div_issue_stall", stall, 0);
      check("div_issue_busy", md_busy, 0);
      tick();
      drive(0, 7, 0, 7, 2, 1, 0, 0, 1);
`ifdef HZ_MD_TRACK_EN
      for (int i = 0; i < 10; i++) begin
         check($sformatf("div_stall_%0d", i), stall, 1);
         check($sformatf("div_busy_%0d", i), md_busy, 1);
         tick();
      end
      check("div_done_stall", stall, 0);
      check("div_done_busy", md_busy, 0);
      tick();
      // Mult: count stall cycles of a following HI/LO user, bounded.
      drive(0, 7, 0, 7, 0, 0, 1, 0, 1);
      tick();
      drive(0, 7, 0, 7, 2, 1, 0, 0, 1);
      begin
         int n = 0;
         while (stall && n < 20) begin
            n++;
            tick();
         end
         check("mult_stall_cycles", n, 5);
      end
      tick();
`else
      check("nomd_stall", stall, 0);
      check("nomd_busy", md_busy, 0);
      tick();
`endif

      // Reset mid-flight: div counting and lw in slot 1.
      drive(0, 7, 0, 7, 0, 0, 1, 1, 1);
      tick();
      drive(0, 7, 0, 7, 8, 2, 0, 0, 0);
      tick();
      drive(8, 1, 8, 1, 0, 0, 0, 0, 1);
      check("pre_rst_stall", stall, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("post_rst_stall", stall, 0);
      check("post_rst_busy", md_busy, 0);
      check("post_rst_fwd_rs", fwd_rs_sel, 0);
      check("post_rst_fwd_rt", fwd_rt_sel, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
